// File: rtl/multdiv_stage_if.sv
// Handshake bundle between the D/X latch side and the iterative multiply/divide unit.
// The master side drives the instruction and operands; the slave side is the unit itself.
interface multdiv_stage_if;
    logic [31:0] DXIR;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        flush;
    logic        md_stall;
    logic        md_ready;
    logic [31:0] md_IR;
    logic [31:0] md_O;

    modport master (
        output DXIR, dataA, dataB, flush,
        input  md_stall, md_ready, md_IR, md_O
    );

    modport slave (
        input  DXIR, dataA, dataB, flush,
        output md_stall, md_ready, md_IR, md_O
    );
endinterface

// File: rtl/multdiv_stage.sv
// Iterative 32-bit signed multiply/divide for the execute stage, 32 steps per operation.
// Define MULTDIV_DIV0_EXC_EN to make divide-by-zero raise the rstatus exception (code 5).
module multdiv_stage (
    input  logic             clock,
    input  logic             reset,
    multdiv_stage_if.slave   bus
);

`ifdef MULTDIV_DIV0_EXC_EN
    localparam logic DIV0_EXC = 1'b1;
`else
    localparam logic DIV0_EXC = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir_q;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg;
    logic        is_div;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] md_ir_q;
    logic [31:0] md_o_q;
    logic        stall;
    logic        ready;

    logic        md_op;
    logic        start;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign md_op = (bus.DXIR[31:27] == 5'd0) &&
                   ((bus.DXIR[6:2] == 5'd6) || (bus.DXIR[6:2] == 5'd7));
    assign start = md_op && !bus.flush;
    assign abs_a = bus.dataA[31] ? -bus.dataA : bus.dataA;
    assign abs_b = bus.dataB[31] ? -bus.dataB : bus.dataB;

    assign bus.md_stall = stall;
    assign bus.md_ready = ready;
    assign bus.md_IR    = md_ir_q;
    assign bus.md_O     = md_o_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        ready      = 1'b0;
        unique case (state)
            IDLE: begin
                stall = start;
                if (start) state_next = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.flush)          state_next = IDLE;
                else if (count == 5'd31) state_next = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            stall = 1'b0;
            ready = 1'b0;
        end
    end

    // Shared accumulator: {partial, multiplier} for mul, {remainder, quotient} for div.
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        rem_shift = acc[63:31];
        rem_diff  = rem_shift - {1'b0, mag_b};
        if (is_div)
            acc_next = rem_diff[32] ? {acc[62:0], 1'b0}
                                    : {rem_diff[31:0], acc[30:0], 1'b1};
        else
            acc_next = {mul_sum, acc[31:1]};
    end

    logic [63:0] prod;
    logic [31:0] quot;
    logic        b_zero;
    logic        exc;
    logic [31:0] raw;
    logic [31:0] fin_ir;
    logic [31:0] fin_o;

    // A positive quotient with bit 31 set only arises from -2^31 / -1.
    always_comb begin
        prod   = neg ? -acc_next : acc_next;
        quot   = neg ? -acc_next[31:0] : acc_next[31:0];
        b_zero = (mag_b == 32'd0);
        if (is_div)
            exc = b_zero ? DIV0_EXC : (!neg && acc_next[31]);
        else
            exc = (prod[63:32] != {32{prod[31]}});
        if (exc)         raw = is_div ? 32'd5 : 32'd4;
        else if (is_div) raw = b_zero ? 32'd0 : quot;
        else             raw = prod[31:0];
        fin_ir = exc ? {ir_q[31:27], 5'd30, ir_q[21:0]} : ir_q;
        fin_o  = (fin_ir[26:22] == 5'd0) ? 32'd0 : raw;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q    <= 32'd0;
            mag_a   <= 32'd0;
            mag_b   <= 32'd0;
            neg     <= 1'b0;
            is_div  <= 1'b0;
            count   <= 5'd0;
            acc     <= 64'd0;
            md_ir_q <= 32'd0;
            md_o_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ir_q   <= bus.DXIR;
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        neg    <= bus.dataA[31] ^ bus.dataB[31];
                        is_div <= bus.DXIR[2];
                        count  <= 5'd0;
                        acc    <= {32'd0, bus.DXIR[2] ? abs_a : abs_b};
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;
                    if (!bus.flush && count == 5'd31) begin
                        md_ir_q <= fin_ir;
                        md_o_q  <= fin_o;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
